// File: rtl/bcd_timekeeper.sv
// bcd_timekeeper: BCD time-of-day core. It counts ms/s/m/H in 24-hour BCD,
// converts the hours for a 12/24-hour display, offers a debounced
// auto-repeat set mode, and emits one-cycle second and midnight strobes.

// One button path: a 2-flop synchroniser, a stability debouncer and a
// press/auto-repeat event generator. Events count only for presses that
// began while edit was high and stayed high.
module bcd_timekeeper_btn #(
  parameter int unsigned DEBOUNCE      = 20,
  parameter int unsigned HOLD_DELAY    = 500,
  parameter int unsigned REPEAT_PERIOD = 200
) (
  input  logic clk_1kHz,
  input  logic resetn,
  input  logic edit_i,
  input  logic btn_i,
  output logic event_o
);
  localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);
  localparam int unsigned RP_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W = $clog2(RP_MAX + 1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [RP_W-1:0] HOLD_LAST = RP_W'(HOLD_DELAY - 1);
  localparam logic [RP_W-1:0] REP_LAST  = RP_W'(REPEAT_PERIOD - 1);

  typedef enum logic {RPT_FIRST, RPT_NEXT} rpt_e;

  logic [1:0]      sync_q;
  logic            level_q;
  logic [DB_W-1:0] db_cnt_q;
  logic [RP_W-1:0] rpt_cnt_q;
  rpt_e            rpt_state_q;
  logic            arm_q;
  logic            event_q;

  // Debounce the synchronised level and time the press/repeat events.
  // NOTE: every register here uses <= so all of them sample pre-edge values;
  // a blocking '=' would let later statements see this edge's new values.
  always_ff @(posedge clk_1kHz or negedge resetn) begin
    if (!resetn) begin
      sync_q      <= '0;
      level_q     <= 1'b0;
      db_cnt_q    <= '0;
      rpt_cnt_q   <= '0;
      rpt_state_q <= RPT_FIRST;
      arm_q       <= 1'b0;
      event_q     <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      event_q <= 1'b0;
      if (sync_q[1] != level_q) begin
        if (db_cnt_q == DB_LAST) begin
          db_cnt_q <= '0;
          level_q  <= sync_q[1];
          if (sync_q[1]) begin
            // Fresh press: arm only if edit is already on.
            arm_q       <= edit_i;
            event_q     <= edit_i;
            rpt_cnt_q   <= '0;
            rpt_state_q <= RPT_FIRST;
          end
        end else begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_q <= '0;
        if (level_q) begin
          if (!edit_i) arm_q <= 1'b0;
          if ((rpt_state_q == RPT_FIRST && rpt_cnt_q == HOLD_LAST) ||
              (rpt_state_q == RPT_NEXT  && rpt_cnt_q == REP_LAST)) begin
            event_q     <= arm_q & edit_i;
            rpt_cnt_q   <= '0;
            rpt_state_q <= RPT_NEXT;
          end else begin
            rpt_cnt_q <= rpt_cnt_q + RP_W'(1);
          end
        end
      end
    end
  end

  assign event_o = event_q;
endmodule

module bcd_timekeeper #(
  parameter int unsigned TICKS_PER_MS  = 1,
  parameter int unsigned DEBOUNCE      = 20,
  parameter int unsigned HOLD_DELAY    = 500,
  parameter int unsigned REPEAT_PERIOD = 200
) (
  input  logic       clk_1kHz,
  input  logic       resetn,
  input  logic       en,
  input  logic       edit,
  input  logic       hr12,
  input  logic       btn_inc_h,
  input  logic       btn_inc_m,
  output logic [3:0] ms2,
  output logic [3:0] ms1,
  output logic [3:0] ms0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] h1,
  output logic [3:0] h0,
  output logic       pm,
  output logic       sec_pulse,
  output logic       day_pulse
);
  localparam logic [15:0] PRE_LAST = 16'(TICKS_PER_MS - 1);

  logic [15:0] pre_q, pre_d;
  logic [3:0]  ms0_q, ms0_d;
  logic [7:0]  ms_hi_q, ms_hi_d;   // {ms2, ms1}
  logic [7:0]  sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic        sec_pulse_q, sec_pulse_d, day_pulse_q, day_pulse_d;
  logic        evt_h, evt_m;
  logic        ms_tick, ms_carry, s_carry, m_carry, h_carry;
  logic [4:0]  hour_bin, disp_bin;
  logic [7:0]  disp_hours;
  logic        disp_pm;

  // Two-digit BCD increment that wraps from 'last' back to 00.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  bcd_timekeeper_btn #(.DEBOUNCE(DEBOUNCE), .HOLD_DELAY(HOLD_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_btn_h (.clk_1kHz(clk_1kHz), .resetn(resetn), .edit_i(edit), .btn_i(btn_inc_h), .event_o(evt_h));
  bcd_timekeeper_btn #(.DEBOUNCE(DEBOUNCE), .HOLD_DELAY(HOLD_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_btn_m (.clk_1kHz(clk_1kHz), .resetn(resetn), .edit_i(edit), .btn_i(btn_inc_m), .event_o(evt_m));

  assign ms_tick  = (pre_q == PRE_LAST);
  assign ms_carry = (ms0_q == 4'd9) && (ms_hi_q == 8'h99);
  assign s_carry  = ms_carry && (sec_q == 8'h59);
  assign m_carry  = s_carry && (min_q == 8'h59);
  assign h_carry  = m_carry && (hour_q == 8'h23);

  // Next-state: set mode, or the carry chain resolved in a single edge.
  // NOTE: every variable gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    pre_d       = pre_q;
    ms0_d       = ms0_q;
    ms_hi_d     = ms_hi_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    sec_pulse_d = 1'b0;
    day_pulse_d = 1'b0;
    if (edit) begin
      pre_d   = '0;
      ms0_d   = '0;
      ms_hi_d = '0;
      sec_d   = '0;
      if (evt_h) hour_d = bcd2_inc(hour_q, 8'h23);
      if (evt_m) min_d  = bcd2_inc(min_q, 8'h59);
    end else if (en) begin
      pre_d = ms_tick ? '0 : pre_q + 16'd1;
      if (ms_tick) begin
        ms0_d = (ms0_q == 4'd9) ? 4'd0 : ms0_q + 4'd1;
        if (ms0_q == 4'd9) ms_hi_d = bcd2_inc(ms_hi_q, 8'h99);
        if (ms_carry) begin
          sec_d       = bcd2_inc(sec_q, 8'h59);
          sec_pulse_d = 1'b1;
        end
        if (s_carry) min_d  = bcd2_inc(min_q, 8'h59);
        if (m_carry) hour_d = bcd2_inc(hour_q, 8'h23);
        if (h_carry) day_pulse_d = 1'b1;
      end
    end
  end

  // Time-of-day and strobe registers.
  always_ff @(posedge clk_1kHz or negedge resetn) begin
    if (!resetn) begin
      pre_q       <= '0;
      ms0_q       <= '0;
      ms_hi_q     <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      ms0_q       <= ms0_d;
      ms_hi_q     <= ms_hi_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      sec_pulse_q <= sec_pulse_d;
      day_pulse_q <= day_pulse_d;
    end
  end

  // Display-only hour conversion; stored time is always 24-hour.
  always_comb begin
    hour_bin   = 5'(hour_q[7:4]) * 5'd10 + 5'(hour_q[3:0]);
    disp_bin   = hour_bin;
    disp_pm    = 1'b0;
    disp_hours = hour_q;
    if (hr12) begin
      disp_pm = (hour_bin >= 5'd12);
      if (hour_bin == 5'd0)       disp_bin = 5'd12;
      else if (hour_bin > 5'd12)  disp_bin = hour_bin - 5'd12;
      disp_hours = (disp_bin >= 5'd10) ? {4'd1, 4'(disp_bin - 5'd10)} : {4'd0, disp_bin[3:0]};
    end
  end

  assign {ms2, ms1} = ms_hi_q;
  assign ms0        = ms0_q;
  assign {s1, s0}   = sec_q;
  assign {m1, m0}   = min_q;
  assign {h1, h0}   = disp_hours;
  assign pm         = disp_pm;
  assign sec_pulse  = sec_pulse_q;
  assign day_pulse  = day_pulse_q;
endmodule
